// File: rtl/nios2_sysid_info.sv
// System-ID and uptime slave: read-only build identity, prescaled free-running
// counter with coherent 64-bit readout, control, sticky wrap status and scratch words.
module nios2_sysid_info #(
  parameter logic [31:0] ID_VALUE  = 32'd1521132484,
  parameter logic [31:0] TIMESTAMP = 32'd0,
  parameter int unsigned TICK_DIV  = 1,
  parameter int unsigned CNT_W     = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam int unsigned      PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    ADDR_ID     = 3'd0,
    ADDR_TS     = 3'd1,
    ADDR_UP_LO  = 3'd2,
    ADDR_UP_HI  = 3'd3,
    ADDR_CTRL   = 3'd4,
    ADDR_STATUS = 3'd5,
    ADDR_SCR0   = 3'd6,
    ADDR_SCR1   = 3'd7
  } addr_e;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic             run_q, run_d;
  logic             wrap_q, wrap_d;
  logic [31:0]      scr0_q, scr0_d;
  logic [31:0]      scr1_q, scr1_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;

  addr_e       addr;
  logic [63:0] cnt_ext;
  logic        tick, wrap, wr_ctrl, clr;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  assign addr    = addr_e'(address);
  assign cnt_ext = 64'(cnt_q);
  assign tick    = run_q && (pre_q == PRE_MAX);
  assign wrap    = tick && (&cnt_q);
  assign wr_ctrl = write && (addr == ADDR_CTRL) && byteenable[0];
  assign clr     = wr_ctrl && writedata[1];

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
    pre_d    = pre_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    run_d    = run_q;
    wrap_d   = wrap_q;
    scr0_d   = scr0_q;
    scr1_d   = scr1_q;
    rdata_d  = rdata_q;
    rvalid_d = read;

    if (run_q) pre_d = tick ? '0 : pre_q + PRE_W'(1);
    if (tick)  cnt_d = cnt_q + CNT_W'(1);

    // A wrap on the same edge as a STATUS read must survive the read-clear.
    if (read && addr == ADDR_STATUS) wrap_d = 1'b0;
    if (wrap)                        wrap_d = 1'b1;

    if (clr) begin
      pre_d  = '0;
      cnt_d  = '0;
      wrap_d = 1'b0;
    end
    if (wr_ctrl) run_d = writedata[0];

    if (write && addr == ADDR_SCR0) scr0_d = be_merge(scr0_q, writedata, byteenable);
    if (write && addr == ADDR_SCR1) scr1_d = be_merge(scr1_q, writedata, byteenable);

    if (read) begin
      unique case (addr)
        ADDR_ID:     rdata_d = ID_VALUE;
        ADDR_TS:     rdata_d = TIMESTAMP;
        ADDR_UP_LO: begin
          rdata_d = cnt_ext[31:0];
          hi_d    = cnt_ext[63:32];
        end
        ADDR_UP_HI:  rdata_d = hi_q;
        ADDR_CTRL:   rdata_d = {31'b0, run_q};
        ADDR_STATUS: rdata_d = {31'b0, wrap_q};
        ADDR_SCR0:   rdata_d = scr0_q;
        ADDR_SCR1:   rdata_d = scr1_q;
        default:     rdata_d = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      run_q    <= 1'b1;
      wrap_q   <= 1'b0;
      scr0_q   <= '0;
      scr1_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      run_q    <= run_d;
      wrap_q   <= wrap_d;
      scr0_q   <= scr0_d;
      scr1_q   <= scr1_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign readdata      = rdata_q;
  assign readdatavalid = rvalid_q;

endmodule

// File: tb/tb_nios2_sysid_info.sv
// Directed bench for nios2_sysid_info: three instances cover the prescaled,
// 64-bit and narrow-counter configurations sharing one clock and reset.
module tb_nios2_sysid_info;

  localparam int NDUT = 3;
  localparam int DA   = 0;  // TICK_DIV=4, CNT_W=64, timestamp set
  localparam int DB   = 1;  // TICK_DIV=1, CNT_W=64
  localparam int DC   = 2;  // TICK_DIV=1, CNT_W=4

  localparam logic [31:0] ID_EXP = 32'd1521132484;
  localparam logic [31:0] TS_EXP = 32'h6543_2100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address       [NDUT];
  logic        read          [NDUT];
  logic        write         [NDUT];
  logic [31:0] writedata     [NDUT];
  logic [3:0]  byteenable    [NDUT];
  logic [31:0] readdata      [NDUT];
  logic        readdatavalid [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  nios2_sysid_info #(.TIMESTAMP(TS_EXP), .TICK_DIV(4), .CNT_W(64)) dut_a (
    .clock(clock), .reset(reset), .address(address[DA]), .read(read[DA]),
    .write(write[DA]), .writedata(writedata[DA]), .byteenable(byteenable[DA]),
    .readdata(readdata[DA]), .readdatavalid(readdatavalid[DA]));

  nios2_sysid_info #(.TICK_DIV(1), .CNT_W(64)) dut_b (
    .clock(clock), .reset(reset), .address(address[DB]), .read(read[DB]),
    .write(write[DB]), .writedata(writedata[DB]), .byteenable(byteenable[DB]),
    .readdata(readdata[DB]), .readdatavalid(readdatavalid[DB]));

  nios2_sysid_info #(.TICK_DIV(1), .CNT_W(4)) dut_c (
    .clock(clock), .reset(reset), .address(address[DC]), .read(read[DC]),
    .write(write[DC]), .writedata(writedata[DC]), .byteenable(byteenable[DC]),
    .readdata(readdata[DC]), .readdatavalid(readdatavalid[DC]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Issue a one-cycle read, then sample valid and data at the following falling edge.
  task automatic rd(input int d, input logic [2:0] a, input string tag, input logic [31:0] exp);
    address[d] = a;
    read[d]    = 1'b1;
    @(negedge clock);
    read[d]    = 1'b0;
    check({tag, "_valid"}, {31'b0, readdatavalid[d]}, 32'd1);
    check(tag, readdata[d], exp);
  endtask

  task automatic wr(input int d, input logic [2:0] a, input logic [31:0] data, input logic [3:0] be);
    address[d]    = a;
    writedata[d]  = data;
    byteenable[d] = be;
    write[d]      = 1'b1;
    @(negedge clock);
    write[d]      = 1'b0;
    byteenable[d] = 4'h0;
  endtask

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      address[d]    = '0;
      read[d]       = 1'b0;
      write[d]      = 1'b0;
      writedata[d]  = '0;
      byteenable[d] = '0;
    end

    // Reset state of all instances
    reset = 1'b1;
    repeat (3) @(negedge clock);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst_rdata%0d", d), readdata[d], 32'h0);
      check($sformatf("rst_valid%0d", d), {31'b0, readdatavalid[d]}, 32'h0);
    end
    reset = 1'b0;

    // Identity words, then valid drops and data holds
    rd(DA, 3'd0, "id", ID_EXP);
    rd(DA, 3'd1, "timestamp", TS_EXP);
    cycles(1);
    check("valid_drop", {31'b0, readdatavalid[DA]}, 32'h0);
    check("rdata_hold", readdata[DA], TS_EXP);
    rd(DA, 3'd4, "ctrl_reset", 32'h1);
    rd(DA, 3'd5, "status_reset", 32'h0);
    rd(DA, 3'd3, "hi_reset", 32'h0);
    rd(DA, 3'd6, "scr0_reset", 32'h0);

    // Prescaler: 40 cycles at TICK_DIV=4, then freeze, then resume mid-period
    do_reset();
    cycles(40);
    rd(DA, 3'd2, "lo_prescaled", 32'd10);
    wr(DA, 3'd4, 32'h0, 4'hF);
    cycles(20);
    rd(DA, 3'd2, "lo_frozen_a", 32'd10);
    rd(DA, 3'd2, "lo_frozen_b", 32'd10);
    rd(DA, 3'd4, "ctrl_run_off", 32'h0);
    wr(DA, 3'd4, 32'h1, 4'hF);
    cycles(2);
    rd(DA, 3'd2, "lo_resumed", 32'd11);

    // Scratch byte enables, read-only write ignored, simultaneous read and write
    wr(DA, 3'd6, 32'hAABB_CCDD, 4'b1111);
    wr(DA, 3'd6, 32'h1122_3344, 4'b0101);
    rd(DA, 3'd6, "scr0_be", 32'hAA22_CC44);
    rd(DA, 3'd7, "scr1_untouched", 32'h0);
    wr(DA, 3'd7, 32'h1234_5678, 4'b1010);
    rd(DA, 3'd7, "scr1_be", 32'h1200_5600);
    wr(DA, 3'd0, 32'hDEAD_BEEF, 4'hF);
    rd(DA, 3'd0, "id_ro", ID_EXP);
    address[DA]    = 3'd7;
    writedata[DA]  = 32'hFFFF_FFFF;
    byteenable[DA] = 4'hF;
    read[DA]       = 1'b1;
    write[DA]      = 1'b1;
    @(negedge clock);
    read[DA]       = 1'b0;
    write[DA]      = 1'b0;
    byteenable[DA] = 4'h0;
    check("rw_same_word_old", readdata[DA], 32'h1200_5600);
    rd(DA, 3'd7, "rw_same_word_new", 32'hFFFF_FFFF);

    // Coherent 64-bit readout: preload the counter just below a low-word carry
    do_reset();
    force dut_b.cnt_q = 64'h0000_0002_FFFF_FFFE;
    #1;
    release dut_b.cnt_q;
    rd(DB, 3'd2, "coh_lo", 32'hFFFF_FFFE);
    cycles(5);
    rd(DB, 3'd3, "coh_hi_snapshot", 32'h2);
    rd(DB, 3'd2, "live_lo", 32'h5);
    rd(DB, 3'd3, "live_hi", 32'h3);

    // Clear on a tick cycle, lane-0 gating, clear with run written 0
    wr(DB, 3'd4, 32'h3, 4'h1);
    rd(DB, 3'd2, "lo_after_clear", 32'h0);
    rd(DB, 3'd4, "ctrl_after_clear", 32'h1);
    wr(DB, 3'd4, 32'h0, 4'hE);
    rd(DB, 3'd4, "ctrl_lane0_off", 32'h1);
    wr(DB, 3'd4, 32'h2, 4'h1);
    cycles(3);
    rd(DB, 3'd2, "lo_clear_stopped", 32'h0);
    rd(DB, 3'd4, "ctrl_clear_stopped", 32'h0);

    // Narrow counter wrap and sticky status
    do_reset();
    cycles(14);
    rd(DC, 3'd5, "status_before_wrap", 32'h0);
    cycles(1);
    rd(DC, 3'd5, "status_sticky", 32'h1);
    rd(DC, 3'd5, "status_cleared", 32'h0);
    cycles(13);
    rd(DC, 3'd5, "status_read_on_wrap", 32'h0);
    rd(DC, 3'd5, "status_kept", 32'h1);
    rd(DC, 3'd2, "lo_narrow", 32'h1);
    rd(DC, 3'd3, "hi_narrow", 32'h0);

    // Reset asserted in a read cycle suppresses the valid
    @(negedge clock);
    address[DA] = 3'd0;
    read[DA]    = 1'b1;
    reset       = 1'b1;
    @(negedge clock);
    read[DA]    = 1'b0;
    check("rst_during_read_valid", {31'b0, readdatavalid[DA]}, 32'h0);
    check("rst_during_read_data", readdata[DA], 32'h0);
    reset       = 1'b0;
    cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
